// File: rtl/i2c_byte_sequencer_pkg.sv
// i2c_seq_pkg: command bits, state encodings and defaults shared by the I2C byte sequencer.
package i2c_seq_pkg;
  localparam int DEF_LEN_W   = 5;
  localparam int DEF_TIMEOUT = 1023;
  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_WRITE = 2;
  localparam int B_READ  = 3;
  localparam int B_ACK   = 4;
  localparam logic [7:0] CMD_START = 8'(1 << B_START);
  localparam logic [7:0] CMD_STOP  = 8'(1 << B_STOP);
  localparam logic [7:0] CMD_WRITE = 8'(1 << B_WRITE);
  localparam logic [7:0] CMD_READ  = 8'(1 << B_READ);
  localparam logic [7:0] CMD_ACK   = 8'(1 << B_ACK);
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WR    = 3'd2;
  localparam logic [2:0] ST_RD    = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_ABORT = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE, S_ADDR = ST_ADDR, S_WR = ST_WR, S_RD = ST_RD,
    S_STOP = ST_STOP, S_ABORT = ST_ABORT, S_DONE = ST_DONE
  } state_t;
  typedef enum logic [1:0] {P_IDLE, P_RISE, P_FALL} phase_t;
endpackage

// File: rtl/i2c_byte_sequencer_if.sv
// i2c_byte_sequencer_if: request/stream side and byte-core side of the sequencer.
interface i2c_byte_sequencer_if import i2c_seq_pkg::*; #(parameter int LEN_W = DEF_LEN_W);
  logic             req_valid, req_ready, req_rw;
  logic [6:0]       req_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       wr_data, rd_data;
  logic             wr_valid, wr_ready, rd_valid, done;
  logic             err_nack, err_al, err_to;
  logic [7:0]       core_cmd, core_din, core_dout;
  logic             core_ena, core_busy, core_ack, core_al;
  modport slave (
    input  req_valid, req_addr, req_rw, req_len, wr_data, wr_valid,
           core_busy, core_ack, core_al, core_dout,
    output req_ready, wr_ready, rd_data, rd_valid, done, err_nack, err_al, err_to,
           core_cmd, core_din, core_ena
  );
  modport master (
    output req_valid, req_addr, req_rw, req_len, wr_data, wr_valid,
           core_busy, core_ack, core_al, core_dout,
    input  req_ready, wr_ready, rd_data, rd_valid, done, err_nack, err_al, err_to,
           core_cmd, core_din, core_ena
  );
endinterface

// File: rtl/i2c_byte_sequencer_cmd_issue.sv
// i2c_cmd_issue: pulses one core command, times out the busy rise, reports completion on busy fall.
module i2c_cmd_issue import i2c_seq_pkg::*; #(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic       busy,
  input  logic       ack,
  input  logic       al,
  input  logic [7:0] dout,
  output logic [7:0] core_cmd,
  output logic       cmp,
  output logic       cmp_ack,
  output logic       cmp_al,
  output logic [7:0] cmp_dout,
  output logic       to_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  phase_t        phase;
  logic [TW-1:0] cnt;
  // to_err fires early enough that the consumer's registered flag lands TIMEOUT cycles after the pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase    <= P_IDLE;
      cnt      <= '0;
      core_cmd <= '0;
      cmp      <= 1'b0;
      cmp_ack  <= 1'b0;
      cmp_al   <= 1'b0;
      cmp_dout <= '0;
      to_err   <= 1'b0;
    end else begin
      core_cmd <= (phase == P_IDLE && start) ? cmd : 8'h00;
      cmp      <= 1'b0;
      to_err   <= 1'b0;
      case (phase)
        P_IDLE: if (start) begin
          phase <= P_RISE;
          cnt   <= '0;
        end
        P_RISE: if (busy) phase <= P_FALL;
          else if (cnt == TW'(TIMEOUT - 2)) begin
            to_err <= 1'b1;
            phase  <= P_IDLE;
          end else cnt <= cnt + 1'b1;
        P_FALL: if (!busy) begin
          cmp      <= 1'b1;
          cmp_ack  <= ack;
          cmp_al   <= al;
          cmp_dout <= dout;
          phase    <= P_IDLE;
        end
        default: phase <= P_IDLE;
      endcase
    end
endmodule

// File: rtl/i2c_byte_sequencer.sv
// i2c_byte_sequencer: expands one address/length request into START, data bytes and STOP for the byte core.
module i2c_byte_sequencer import i2c_seq_pkg::*; #(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic clk,
  input logic rst_n,
  i2c_byte_sequencer_if.slave bus
);
  state_t           state;
  logic             pend, rw, start, cmp, c_ack, c_al, to_err;
  logic [7:0]       cmd, c_dout;
  logic [LEN_W-1:0] cnt, cnt_nx;
  assign cnt_nx = cnt - LEN_W'(cnt != '0);
  // pend blocks a new command until the previous one completes or times out
  always_comb begin
    start = !pend && (state == S_IDLE ? bus.req_valid && bus.req_ready :
                      state == S_WR   ? bus.wr_valid :
                      state == S_RD || state == S_STOP);
    cmd   = state == S_IDLE ? (CMD_START | CMD_WRITE) :
            state == S_WR   ? CMD_WRITE :
            state == S_RD   ? (CMD_READ | (cnt != LEN_W'(1) ? CMD_ACK : 8'h00)) : CMD_STOP;
  end
  i2c_cmd_issue #(.TIMEOUT(TIMEOUT)) u_issue (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd),
    .busy(bus.core_busy), .ack(bus.core_ack), .al(bus.core_al), .dout(bus.core_dout),
    .core_cmd(bus.core_cmd), .cmp(cmp), .cmp_ack(c_ack), .cmp_al(c_al), .cmp_dout(c_dout),
    .to_err(to_err)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= S_IDLE;
      pend          <= 1'b0;
      rw            <= 1'b0;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
      bus.core_ena  <= 1'b0;
      bus.core_din  <= '0;
      bus.wr_ready  <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.rd_data   <= '0;
      bus.done      <= 1'b0;
      bus.err_nack  <= 1'b0;
      bus.err_al    <= 1'b0;
      bus.err_to    <= 1'b0;
    end else begin
      bus.wr_ready <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.done     <= 1'b0;
      if (start) pend <= 1'b1;
      if (to_err) begin
        pend       <= 1'b0;
        bus.err_to <= 1'b1;
        bus.done   <= 1'b1;
        state      <= S_DONE;
      end else case (state)
        S_IDLE: if (start) begin
          bus.req_ready <= 1'b0;
          bus.core_ena  <= 1'b1;
          bus.core_din  <= {bus.req_addr, bus.req_rw};
          bus.err_nack  <= 1'b0;
          bus.err_al    <= 1'b0;
          bus.err_to    <= 1'b0;
          cnt           <= bus.req_len;
          rw            <= bus.req_rw;
          state         <= S_ADDR;
        end
        S_ADDR: if (cmp) begin
          pend <= 1'b0;
          if (c_al) begin
            bus.err_al <= 1'b1;
            state      <= S_ABORT;
          end else if (!c_ack) begin
            bus.err_nack <= 1'b1;
            state        <= S_STOP;
          end else state <= cnt == '0 ? S_STOP : rw ? S_RD : S_WR;
        end
        S_WR: begin
          if (start) begin
            bus.wr_ready <= 1'b1;
            bus.core_din <= bus.wr_data;
          end
          if (cmp) begin
            pend <= 1'b0;
            if (c_al) begin
              bus.err_al <= 1'b1;
              state      <= S_ABORT;
            end else if (!c_ack) begin
              bus.err_nack <= 1'b1;
              state        <= S_STOP;
            end else begin
              cnt <= cnt_nx;
              if (cnt_nx == '0) state <= S_STOP;
            end
          end
        end
        S_RD: if (cmp) begin
          pend <= 1'b0;
          if (c_al) begin
            bus.err_al <= 1'b1;
            state      <= S_ABORT;
          end else begin
            bus.rd_data  <= c_dout;
            bus.rd_valid <= 1'b1;
            cnt          <= cnt_nx;
            if (cnt_nx == '0) state <= S_STOP;
          end
        end
        S_STOP: if (cmp) begin
          pend <= 1'b0;
          if (c_al) bus.err_al <= 1'b1;
          bus.done <= 1'b1;
          state    <= S_DONE;
        end
        S_ABORT: begin
          bus.done <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          bus.core_ena  <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// tb_i2c_byte_sequencer: table-driven transactions against a behavioural byte-core model, plus timeout and reset sequences.
module tb_i2c_byte_sequencer;
  localparam int TIMEOUT = 1023;
  typedef struct packed {
    logic [6:0]  addr;
    logic        rw;
    logic [4:0]  len;
    logic [23:0] wd;
    logic [23:0] rd;
    int          nack_at;
    int          al_at;
    logic [47:0] cmd;
    logic [47:0] din;
    int          nwr;
    int          nrdv;
    logic [23:0] rdo;
    logic [2:0]  err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_byte_sequencer_if #(.LEN_W(5)) bus();
  i2c_byte_sequencer #(.LEN_W(5), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          checks = 0, errors = 0;
  int          cfg_nack = 0, cfg_al = 0;
  logic [23:0] cfg_rd = '0;
  logic        no_busy = 1'b0;
  int          nlog = 0;
  logic [47:0] obs_cmd = '0, obs_din = '0;
  logic [23:0] rdsh = '0;
  logic [7:0]  cur = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {bus.req_ready, bus.core_ena, bus.core_cmd, bus.core_din, bus.rd_data,
            bus.rd_valid, bus.wr_ready, bus.done, bus.err_nack, bus.err_al, bus.err_to};
  endfunction

  // byte-core model: busy for three cycles per command, response applied as busy falls
  initial begin
    bus.core_busy = 1'b0; bus.core_ack = 1'b0; bus.core_al = 1'b0; bus.core_dout = '0;
    forever begin
      @(negedge clk);
      if (bus.core_cmd != 8'h00) begin
        cur = bus.core_cmd;
        if (cur[0]) begin nlog = 0; obs_cmd = '0; obs_din = '0; rdsh = cfg_rd; end
        nlog++;
        obs_cmd = {obs_cmd[39:0], cur};
        obs_din = {obs_din[39:0], bus.core_din};
        if (!no_busy) begin
          bus.core_al = 1'b0;
          bus.core_busy = 1'b1;
          repeat (3) @(negedge clk);
          bus.core_ack = nlog != cfg_nack;
          bus.core_al = nlog == cfg_al;
          if (cur[3]) begin bus.core_dout = rdsh[23:16]; rdsh = rdsh << 8; end
          bus.core_busy = 1'b0;
        end
      end
    end
  end

  task automatic request(input logic [6:0] a, input logic r, input logic [4:0] l);
    @(negedge clk);
    bus.req_addr = a; bus.req_rw = r; bus.req_len = l; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic run(input vec_t v);
    int nwr = 0, nrdv = 0, cyc = 0;
    logic [23:0] ws = v.wd, ord = '0;
    logic [2:0] err = '0;
    logic got = 1'b0;
    cfg_nack = v.nack_at; cfg_al = v.al_at; cfg_rd = v.rd;
    bus.wr_valid = !v.rw && v.len != 0;
    bus.wr_data = ws[23:16];
    request(v.addr, v.rw, v.len);
    while (!got && cyc < 300) begin
      if (bus.wr_ready) begin
        nwr++; ws = ws << 8;
        bus.wr_valid = nwr < int'(v.len);
        bus.wr_data = ws[23:16];
      end
      if (bus.rd_valid) begin nrdv++; ord = {ord[15:0], bus.rd_data}; end
      if (bus.done) begin got = 1'b1; err = {bus.err_nack, bus.err_al, bus.err_to}; end
      else begin @(negedge clk); cyc++; end
    end
    bus.wr_valid = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    chk("cmd_seq", 64'(obs_cmd), 64'(v.cmd));
    chk("din_seq", 64'(obs_din), 64'(v.din));
    chk("wr_ready_count", 64'(nwr), 64'(v.nwr));
    chk("rd_valid_count", 64'(nrdv), 64'(v.nrdv));
    chk("rd_bytes", 64'(ord), 64'(v.rdo));
    chk("err_at_done", 64'(err), 64'(v.err));
    @(negedge clk);
    chk("ena_ready_err_after", 64'({bus.core_ena, bus.req_ready, bus.err_nack, bus.err_al, bus.err_to}),
        64'({1'b0, 1'b1, v.err}));
  endtask

  vec_t vt[11];
  vec_t probe;

  initial begin
    int t = 0;
    int cyc = 0;
    vt[0]  = '{7'h50, 1'b0, 5'd2, 24'hA53C00, 24'h0, 0, 0, 48'h05040402, 48'hA0A53C3C, 2, 0, 24'h0, 3'b000};
    vt[1]  = '{7'h50, 1'b1, 5'd3, 24'h0, 24'h112233, 0, 0, 48'h0518180802, 48'hA1A1A1A1A1, 0, 3, 24'h112233, 3'b000};
    vt[2]  = '{7'h50, 1'b0, 5'd2, 24'hA53C00, 24'h0, 1, 0, 48'h0502, 48'hA0A0, 0, 0, 24'h0, 3'b100};
    vt[3]  = '{7'h50, 1'b0, 5'd2, 24'hA53C00, 24'h0, 0, 3, 48'h050404, 48'hA0A53C, 2, 0, 24'h0, 3'b010};
    vt[4]  = '{7'h3C, 1'b0, 5'd0, 24'h0, 24'h0, 0, 0, 48'h0502, 48'h7878, 0, 0, 24'h0, 3'b000};
    vt[5]  = '{7'h2A, 1'b1, 5'd1, 24'h0, 24'h7E0000, 0, 0, 48'h050802, 48'h555555, 0, 1, 24'h00007E, 3'b000};
    vt[6]  = '{7'h50, 1'b1, 5'd2, 24'h0, 24'h99AA00, 0, 2, 48'h0518, 48'hA1A1, 0, 0, 24'h0, 3'b010};
    vt[7]  = '{7'h10, 1'b0, 5'd0, 24'h0, 24'h0, 0, 2, 48'h0502, 48'h2020, 0, 0, 24'h0, 3'b010};
    vt[8]  = '{7'h50, 1'b1, 5'd2, 24'h0, 24'h0, 1, 0, 48'h0502, 48'hA1A1, 0, 0, 24'h0, 3'b100};
    vt[9]  = '{7'h7F, 1'b0, 5'd3, 24'h010203, 24'h0, 0, 0, 48'h0504040402, 48'hFE01020303, 3, 0, 24'h0, 3'b000};
    vt[10] = '{7'h21, 1'b0, 5'd3, 24'h102030, 24'h0, 3, 0, 48'h05040402, 48'h42102020, 2, 0, 24'h0, 3'b100};
    probe  = '{7'h08, 1'b0, 5'd0, 24'h0, 24'h0, 0, 0, 48'h0502, 48'h1010, 0, 0, 24'h0, 3'b000};
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_rw = 1'b0; bus.req_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 64'(out_vec()), 64'h8000_0000);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) run(vt[i]);

    // no busy response: timeout counted from the START pulse cycle
    no_busy = 1'b1;
    cfg_nack = 0; cfg_al = 0;
    request(7'h50, 1'b0, 5'd1);
    chk("to_pulse", 64'(bus.core_cmd), 64'h05);
    t = 0;
    while (!bus.err_to && t < TIMEOUT + 20) begin @(negedge clk); t++; end
    chk("to_cycles", 64'(t), 64'(TIMEOUT));
    chk("to_done", 64'({bus.done, bus.err_nack, bus.err_al, bus.err_to}), 64'b1001);
    repeat (3) @(negedge clk);
    chk("to_no_stop", 64'(obs_cmd), 64'h05);
    no_busy = 1'b0;

    // asynchronous reset in the middle of a read
    cfg_rd = 24'h112233;
    request(7'h50, 1'b1, 5'd3);
    chk("err_cleared_on_accept", 64'({bus.err_nack, bus.err_al, bus.err_to}), 64'd0);
    cyc = 0;
    while (!bus.rd_valid && cyc < 200) begin @(negedge clk); cyc++; end
    chk("rd_before_reset", 64'({bus.rd_valid, bus.rd_data}), 64'h111);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_state", 64'(out_vec()), 64'h8000_0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run(probe);
    run(vt[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_byte_sequencer.md
Name: i2c_byte_sequencer

Overview:
- Transaction-level front end that sits directly upstream of the I2C byte FSM core and drives its cmd/din/ena inputs.
- Accepts one request (7-bit address, direction, length) and expands it into START+address, N data bytes and STOP.
- Streams write bytes in and read bytes out, and reports NACK, arbitration-loss and timeout errors.
- Operates in master mode only.

Parameters:
- LEN_W, 5, width of req_len; maximum transfer is 2^LEN_W-1 data bytes.
- TIMEOUT, 1023, clk cycles allowed for core_busy to rise after a command pulse.

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- req_valid  in  1  transaction request
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready
- req_addr  in  7  slave address
- req_rw  in  1  1 = read, 0 = write
- req_len  in  LEN_W  data byte count; 0 = address-only probe
- wr_data  in  8  write byte
- wr_valid  in  1  write byte available
- wr_ready  out  1  one-cycle pulse; wr_data consumed
- rd_data  out  8  read byte
- rd_valid  out  1  one-cycle pulse; no backpressure
- done  out  1  one-cycle pulse at end of transaction
- err_nack  out  1  error flag
- err_al  out  1  error flag
- err_to  out  1  error flag
- core_cmd  out  8  command to core; nonzero for exactly one cycle per command
- core_din  out  8  byte to core; held stable while the command executes
- core_ena  out  1  bus driver enable
- core_busy  in  1  core is executing a command
- core_ack  in  1  after a write: 1 = slave ACKed
- core_al  in  1  arbitration lost
- core_dout  in  8  received byte

Behaviour:
- Reset, and any assertion of rst_ including mid-transfer, forces:
  - state IDLE, req_ready=1, core_ena=0, core_cmd=0, core_din=0, all pulses 0, err_* = 0, rd_data=0.
  - The bus is released immediately; no STOP is generated.
- Command bits, one cycle each: START=bit0, STOP=bit1, WRITE=bit2, READ=bit3, ACK_OUT=bit4.
- Issue/wait protocol:
  - Drive core_cmd for 1 cycle.
  - Wait for core_busy=1, which must occur within TIMEOUT cycles, else err_to.
  - Wait for core_busy=0; sample core_ack, core_al and core_dout on that cycle.
- States and transitions:
  - IDLE: on accept, latch addr/rw/len and set core_ena=1. Issue START|WRITE with din={addr,rw}. Go to ADDR.
  - ADDR complete:
    - al → ABORT.
    - !ack → err_nack=1, go to STOP.
    - len==0 → STOP.
    - rw=0 → WR.
    - rw=1 → RD.
  - WR: wait for wr_valid (bus held, no timeout). Pulse wr_ready, latch din, issue WRITE. On completion:
    - al → ABORT.
    - !ack → err_nack=1, STOP; remaining bytes are not consumed.
    - otherwise decrement count; count==0 → STOP, else stay in WR.
  - RD: issue READ, with ACK_OUT=1 except on the last byte (ACK_OUT=0, master NACK). On completion:
    - al → ABORT, without a rd_valid pulse.
    - otherwise rd_data=core_dout and rd_valid pulses the next cycle; decrement count; count==0 → STOP.
  - STOP: issue STOP. On completion → DONE; al during STOP → err_al.
  - ABORT: err_al=1, no STOP issued → DONE.
  - DONE: done=1 for 1 cycle, core_ena=0 → IDLE.
- Timeout in any state: err_to=1 → DONE, with no STOP.
- Error flags:
  - Valid in the done cycle.
  - Held until the next request is accepted, then cleared.
  - Multiple flags may be set together.
- Counter is LEN_W bits and never wraps: it is decremented only when nonzero.
- req_valid outside IDLE is ignored; it is not queued.
- Latency: accept → START pulse is 1 cycle; done follows STOP completion by 1 cycle.

Decomposition:
- Package i2c_seq_pkg holds:
  - the CMD bit positions;
  - the state encoding localparams (IDLE, ADDR, WR, RD, STOP, ABORT, DONE);
  - the default TIMEOUT.
- Sub-module i2c_cmd_issue:
  - one-cycle cmd pulse, busy-rise timeout counter, busy-fall detection.
  - Outputs a cmp pulse with sampled ack/al/dout, and to_err.
  - Reused for every state.

Test Plan:
- Write addr=0x50, len=2, bytes 0xA5,0x3C, core ACKs all → cmds START|WRITE with din=0xA0, WRITE din 0xA5, WRITE din 0x3C, STOP; two wr_ready pulses; done with no errors.
- Read addr=0x50, len=3, core_dout 0x11,0x22,0x33 → READ cmds with ACK_OUT 1,1,0; rd_valid×3 with those values; STOP; done.
- Address NACK (core_ack=0 after addr) → STOP issued, err_nack=1 at done, wr_ready never pulses.
- core_al=1 on the 2nd write byte → no STOP, err_al=1, done, core_ena=0 the next cycle.
- core_busy never rises → err_to=1 exactly TIMEOUT cycles after the cmd pulse; done.
- Assert rst_ low mid-read → all outputs take their reset values asynchronously; a new request after reset completes normally; len=0 probe gives START|WRITE then STOP only.
